// File: rtl/pio_delay_sideset_if.sv
// Decoder-to-issue-stage bundle: decoded instruction fields plus the stage's
// ready/done handshake and side-set pin drive outputs.
interface pio_delay_sideset_if #(
  parameter int NUM_PINS = 32
);
  logic                issue_valid;
  logic [4:0]          delay;
  logic [4:0]          side_set;
  logic                sideset_enabled;
  logic [2:0]          sideset_count;
  logic [4:0]          sideset_base;
  logic                side_pindir;
  logic                exec_stall;
  logic                ready;
  logic                done;
  logic [NUM_PINS-1:0] side_out;
  logic [NUM_PINS-1:0] side_pins_mask;
  logic [NUM_PINS-1:0] side_dirs_mask;

  modport master (
    output issue_valid, delay, side_set, sideset_enabled, sideset_count,
           sideset_base, side_pindir, exec_stall,
    input  ready, done, side_out, side_pins_mask, side_dirs_mask
  );

  modport slave (
    input  issue_valid, delay, side_set, sideset_enabled, sideset_count,
           sideset_base, side_pindir, exec_stall,
    output ready, done, side_out, side_pins_mask, side_dirs_mask
  );
endinterface

// File: rtl/pio_delay_sideset.sv
// PIO issue/timing stage: side-set lands 1 cycle after accept, done 1 cycle after completion.
// Backpressure: ready drops for the whole execute-stall plus delay window, and while en=0 or restart.
module pio_delay_sideset #(
  parameter int NUM_PINS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    restart,
  pio_delay_sideset_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DELAY} state_t;

  state_t              state;
  logic [4:0]          cnt;
  logic                done_q;
  logic [NUM_PINS-1:0] side_out_q;
  logic [NUM_PINS-1:0] pins_mask_q;
  logic [NUM_PINS-1:0] dirs_mask_q;

  logic                ready_c;
  logic                accept;
  logic [2:0]          ss_n;
  logic [NUM_PINS-1:0] side_out_nxt;
  logic [NUM_PINS-1:0] pins_mask_nxt;
  logic [NUM_PINS-1:0] dirs_mask_nxt;
  int                  idx;

  assign ready_c = ~reset & en & ~restart & (state == IDLE);
  assign accept  = bus.issue_valid & ready_c;
  assign ss_n    = (bus.sideset_count > 3'd5) ? 3'd5 : bus.sideset_count;

  // Side-set bits are scattered to pin positions modulo the GPIO width.
  always_comb begin
    side_out_nxt  = side_out_q;
    pins_mask_nxt = '0;
    dirs_mask_nxt = '0;
    idx           = 0;
    if (accept && bus.sideset_enabled) begin
      for (int i = 0; i < 5; i++) begin
        if (i < int'(ss_n)) begin
          idx               = (int'(bus.sideset_base) + i) % NUM_PINS;
          side_out_nxt[idx] = bus.side_set[i];
          if (bus.side_pindir) dirs_mask_nxt[idx] = 1'b1;
          else                 pins_mask_nxt[idx] = 1'b1;
        end
      end
    end
  end

  // In EXEC, cnt parks the latched delay until the stall clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      done_q      <= 1'b0;
      side_out_q  <= '0;
      pins_mask_q <= '0;
      dirs_mask_q <= '0;
    end else begin
      side_out_q  <= side_out_nxt;
      pins_mask_q <= pins_mask_nxt;
      dirs_mask_q <= dirs_mask_nxt;
      done_q      <= 1'b0;
      if (restart) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (en) begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (bus.exec_stall) begin
                state <= EXEC;
                cnt   <= bus.delay;
              end else if (bus.delay == 5'd0) begin
                done_q <= 1'b1;
              end else begin
                state <= DELAY;
                cnt   <= bus.delay;
              end
            end
          end
          EXEC: begin
            if (!bus.exec_stall) begin
              if (cnt == 5'd0) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end else begin
                state <= DELAY;
              end
            end
          end
          DELAY: begin
            if (cnt <= 5'd1) begin
              state  <= IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.ready          = ready_c;
  assign bus.done           = done_q;
  assign bus.side_out       = side_out_q;
  assign bus.side_pins_mask = pins_mask_q;
  assign bus.side_dirs_mask = dirs_mask_q;

endmodule
